// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM arbiter: FSM state encoding, requester IDs and
// the default RAM read latency.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_t;

  localparam int DEFAULT_RD_LAT = 1;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the port that did not win last time
// is chosen. Purely combinational; the grant history is owned by the caller.
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    lastGrant,
  output logic       valid,
  output req_id_t    winner
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    valid  = |req;
    winner = REQ_FETCH;
    if (&req) begin
      winner = (lastGrant == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
    end else if (req[1]) begin
      winner = REQ_DATA;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports onto one single-port
// RAM, sequences the access and returns a one-cycle ready with read data.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = DEFAULT_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic              fetchReady,
  input  logic              dataReq,
  input  logic              dataWe,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [DATA_W-1:0] dataWdata,
  output logic              dataReady,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [DATA_W-1:0] ramData,
  output logic              ramWren,
  output logic              ramRead,
  input  logic [DATA_W-1:0] ramQ,
  output logic              busy
);

  localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

  state_t     state, state_next;
  req_id_t    grant_id, last_grant, winner;
  logic       op_write;
  logic       pick_valid;
  logic [1:0] wait_cnt;

  rr_pick2 u_pick (
    .req       ({dataReq, fetchReq}),
    .lastGrant (last_grant),
    .valid     (pick_valid),
    .winner    (winner)
  );

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Strobes are decoded from state, so a reset drops them on the next edge.
  always_comb begin
    state_next = state;
    ramWren    = 1'b0;
    ramRead    = 1'b0;
    fetchReady = 1'b0;
    dataReady  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) state_next = ACCESS;
      end
      ACCESS: begin
        ramWren    = op_write;
        ramRead    = !op_write;
        state_next = op_write ? DONE : WAIT;
      end
      WAIT: begin
        ramRead = 1'b1;
        if (wait_cnt == 2'd0) state_next = DONE;
      end
      DONE: begin
        fetchReady = (grant_id == REQ_FETCH);
        dataReady  = (grant_id == REQ_DATA);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Request fields are latched at grant; later changes on the ports are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      ramAddress <= '0;
      ramData    <= '0;
      rdata      <= '0;
      last_grant <= REQ_DATA;
      grant_id   <= REQ_FETCH;
      op_write   <= 1'b0;
      wait_cnt   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id   <= winner;
            last_grant <= winner;
            if (winner == REQ_DATA) begin
              ramAddress <= dataAddr;
              op_write   <= dataWe;
              if (dataWe) ramData <= dataWdata;
            end else begin
              ramAddress <= fetchAddr;
              op_write   <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (!op_write) wait_cnt <= WAIT_LOAD;
        end
        WAIT: begin
          if (wait_cnt == 2'd0) rdata    <= ramQ;
          else                  wait_cnt <= wait_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level memory/arbitration model.
module tb_ram_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam bit P_FETCH = 1'b0;
  localparam bit P_DATA  = 1'b1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT A: default read latency
  logic        fetch_req, fetch_ready, data_req, data_we, data_ready;
  logic        ram_wren, ram_read, busy;
  logic [15:0] fetch_addr, data_addr, data_wdata, rdata;
  logic [15:0] ram_address, ram_data, ram_q;

  // DUT B: read latency 3
  logic        b_fetch_req, b_fetch_ready, b_data_req, b_data_we, b_data_ready;
  logic        b_ram_wren, b_ram_read, b_busy;
  logic [15:0] b_fetch_addr, b_data_addr, b_data_wdata, b_rdata;
  logic [15:0] b_ram_address, b_ram_data, b_ram_q;

  ram_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT_A)) dut_a (
    .clk(clk), .reset(reset),
    .fetchReq(fetch_req), .fetchAddr(fetch_addr), .fetchReady(fetch_ready),
    .dataReq(data_req), .dataWe(data_we), .dataAddr(data_addr),
    .dataWdata(data_wdata), .dataReady(data_ready), .rdata(rdata),
    .ramAddress(ram_address), .ramData(ram_data), .ramWren(ram_wren),
    .ramRead(ram_read), .ramQ(ram_q), .busy(busy)
  );

  ram_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT_B)) dut_b (
    .clk(clk), .reset(reset),
    .fetchReq(b_fetch_req), .fetchAddr(b_fetch_addr), .fetchReady(b_fetch_ready),
    .dataReq(b_data_req), .dataWe(b_data_we), .dataAddr(b_data_addr),
    .dataWdata(b_data_wdata), .dataReady(b_data_ready), .rdata(b_rdata),
    .ramAddress(b_ram_address), .ramData(b_ram_data), .ramWren(b_ram_wren),
    .ramRead(b_ram_read), .ramQ(b_ram_q), .busy(b_busy)
  );

  // Behavioural RAMs: address sampled every edge, q valid RD_LAT edges later.
  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  logic [15:0] pipe_b [0:2];

  always @(posedge clk) begin
    if (ram_wren) mem_a[ram_address] <= ram_data;
    ram_q <= mem_a[ram_address];
  end

  always @(posedge clk) begin
    if (b_ram_wren) mem_b[b_ram_address] <= b_ram_data;
    pipe_b[0] <= mem_b[b_ram_address];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_ram_q = pipe_b[2];

  // Reference model: expected memory contents and round-robin history.
  logic [15:0] ref_mem [logic [15:0]];
  bit          last_win;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One isolated transaction on DUT A, started from IDLE.
  task automatic txn(input bit port, input bit we, input logic [15:0] addr,
                     input logic [15:0] wd, input string tag);
    int cyc, wren_n, read_n, wrong_n;
    bit seen;
    cyc = 0; wren_n = 0; read_n = 0; wrong_n = 0; seen = 1'b0;
    if (port == P_FETCH) begin
      fetch_req = 1'b1; fetch_addr = addr;
    end else begin
      data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wd;
    end
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        check({tag, "/addr"}, ram_address, addr);
        if (we) check({tag, "/wdata"}, ram_data, wd);
        fetch_addr = 16'($urandom);
        data_addr  = 16'($urandom);
        data_wdata = 16'($urandom);
      end
      wren_n  += int'(ram_wren);
      read_n  += int'(ram_read);
      wrong_n += int'((port == P_FETCH) ? data_ready : fetch_ready);
      seen     = (port == P_FETCH) ? fetch_ready : data_ready;
    end
    fetch_req = 1'b0;
    data_req  = 1'b0;
    check({tag, "/latency"}, cyc, we ? 2 : 2 + LAT_A);
    check({tag, "/wren_cycles"}, wren_n, we ? 1 : 0);
    check({tag, "/read_cycles"}, read_n, we ? 0 : LAT_A + 1);
    check({tag, "/other_ready"}, wrong_n, 0);
    if (we) ref_mem[addr] = wd;
    else    check({tag, "/rdata"}, rdata, ref_mem[addr]);
    last_win = port;
    tick();
    check({tag, "/idle"}, busy, 1'b0);
  endtask

  initial begin
    int cyc, overlap, cnt_d, cnt_f, cnt_r, rdy_cyc;
    bit seen, exp_w, exp_we, f, d, dwe;
    logic [15:0] fa, da, dwd, exp_addr;

    reset = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0; data_req = 1'b0; data_we = 1'b0;
    data_addr = '0; data_wdata = '0;
    b_fetch_req = 1'b0; b_fetch_addr = '0; b_data_req = 1'b0; b_data_we = 1'b0;
    b_data_addr = '0; b_data_wdata = '0;
    tick(); tick();
    check("rst/busy", busy, 1'b0);
    check("rst/wren", ram_wren, 1'b0);
    check("rst/read", ram_read, 1'b0);
    check("rst/ready", {fetch_ready, data_ready}, 2'b00);
    check("rst/rdata", rdata, 16'h0);
    check("rst/ram_address", ram_address, 16'h0);
    check("rst/ram_data", ram_data, 16'h0);
    reset = 1'b0;
    last_win = P_DATA;

    // Basic write then read-back
    txn(P_DATA, 1'b1, 16'h0010, 16'hBEEF, "wr10");
    txn(P_DATA, 1'b0, 16'h0010, 16'h0000, "rd10");

    // Round-robin under continuous contention, starting from reset history
    txn(P_DATA, 1'b1, 16'h0100, 16'h1111, "pre100");
    txn(P_DATA, 1'b1, 16'h0200, 16'h2222, "pre200");
    reset = 1'b1; tick(); reset = 1'b0;
    last_win = P_DATA;
    fetch_req = 1'b1; fetch_addr = 16'h0100;
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      exp_w = ~last_win;
      cyc = 0; overlap = 0; seen = 1'b0;
      while (!seen && cyc < 20) begin
        tick();
        cyc++;
        overlap += int'(fetch_ready && data_ready);
        seen = fetch_ready | data_ready;
      end
      check("rr/latency", cyc, 2 + LAT_A);
      check("rr/overlap", overlap, 0);
      check("rr/winner", {fetch_ready, data_ready}, exp_w ? 2'b01 : 2'b10);
      check("rr/rdata", rdata, ref_mem[exp_w ? 16'h0200 : 16'h0100]);
      last_win = exp_w;
      if (exp_w == P_DATA) data_req = 1'b0;
      else                 fetch_req = 1'b0;
      tick();
      if (k < 3) begin
        if (exp_w == P_DATA) data_req = 1'b1;
        else                 fetch_req = 1'b1;
      end else begin
        fetch_req = 1'b0;
        data_req  = 1'b0;
      end
    end
    tick();

    // Longer read latency on DUT B
    b_data_req = 1'b1; b_data_we = 1'b1; b_data_addr = 16'h0005; b_data_wdata = 16'h1234;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      tick(); cyc++; seen = b_data_ready;
    end
    b_data_req = 1'b0;
    check("lat3/wr_latency", cyc, 2);
    tick();
    b_fetch_req = 1'b1; b_fetch_addr = 16'h0005;
    cyc = 0; seen = 1'b0; cnt_r = 0; cnt_d = 0;
    while (!seen && cyc < 20) begin
      tick(); cyc++;
      cnt_r += int'(b_ram_read);
      cnt_d += int'(b_data_ready);
      seen = b_fetch_ready;
    end
    b_fetch_req = 1'b0;
    check("lat3/latency", cyc, 2 + LAT_B);
    check("lat3/read_cycles", cnt_r, LAT_B + 1);
    check("lat3/rdata", b_rdata, 16'h1234);
    check("lat3/no_data_ready", cnt_d, 0);
    tick();
    check("lat3/idle", b_busy, 1'b0);

    // Reset during WAIT aborts the read without a ready pulse
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0010;
    tick(); tick();
    check("abort/in_wait", ram_read, 1'b1);
    reset = 1'b1; data_req = 1'b0;
    tick();
    check("abort/busy", busy, 1'b0);
    check("abort/strobes", {ram_read, ram_wren, data_ready, fetch_ready}, 4'b0000);
    check("abort/rdata", rdata, 16'h0);
    reset = 1'b0;
    last_win = P_DATA;
    cnt_d = 0;
    repeat (4) begin
      tick(); cnt_d += int'(data_ready);
    end
    check("abort/no_ready", cnt_d, 0);
    txn(P_FETCH, 1'b0, 16'h0010, 16'h0000, "fetch_after_abort");

    // Fetch pulse during a write; data request dropped right after grant
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0020; data_wdata = 16'h5A5A;
    cnt_d = 0; cnt_f = 0; cnt_r = 0; rdy_cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin
        fetch_req = 1'b1; fetch_addr = 16'h0010; data_req = 1'b0;
      end
      if (c == 2) fetch_req = 1'b0;
      cnt_d += int'(data_ready);
      cnt_f += int'(fetch_ready);
      cnt_r += int'(ram_read);
      if (data_ready) rdy_cyc = c;
    end
    ref_mem[16'h0020] = 16'h5A5A;
    last_win = P_DATA;
    check("pulse/data_ready_count", cnt_d, 1);
    check("pulse/data_ready_cycle", rdy_cyc, 2);
    check("pulse/no_fetch_ready", cnt_f, 0);
    check("pulse/no_read_access", cnt_r, 0);
    txn(P_DATA, 1'b0, 16'h0020, 16'h0000, "rd20");

    // Randomized traffic against the model
    for (int a = 0; a < 8; a++)
      txn(P_DATA, 1'b1, 16'h0300 + 16'(a), 16'($urandom), "prefill");
    for (int i = 0; i < 24; i++) begin
      f   = 1'($urandom_range(0, 1));
      d   = 1'($urandom_range(0, 1));
      if (!f && !d) d = 1'b1;
      fa  = 16'h0300 + 16'($urandom_range(0, 7));
      da  = 16'h0300 + 16'($urandom_range(0, 7));
      dwe = 1'($urandom_range(0, 1));
      dwd = 16'($urandom);
      fetch_req = f; fetch_addr = fa;
      data_req = d; data_we = dwe; data_addr = da; data_wdata = dwd;
      exp_w    = (f && d) ? ~last_win : d;
      exp_we   = exp_w & dwe;
      exp_addr = exp_w ? da : fa;
      cyc = 0; overlap = 0; seen = 1'b0;
      while (!seen && cyc < 20) begin
        tick(); cyc++;
        if (cyc == 1) check("rand/addr", ram_address, exp_addr);
        overlap += int'(fetch_ready && data_ready);
        seen = fetch_ready | data_ready;
      end
      fetch_req = 1'b0;
      data_req  = 1'b0;
      check("rand/winner", {fetch_ready, data_ready}, exp_w ? 2'b01 : 2'b10);
      check("rand/latency", cyc, exp_we ? 2 : 2 + LAT_A);
      check("rand/overlap", overlap, 0);
      if (exp_we) ref_mem[da] = dwd;
      else        check("rand/rdata", rdata, ref_mem[exp_addr]);
      last_win = exp_w;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-port arbiter and sequencer for the shared 16-bit single-port RAM wrapper (RAM_CORE plus readMem/memDataReady). It arbitrates between the instruction-fetch port (read-only) and the load/store data port (read/write). It drives the RAM address, data, wren and readMem signals, counts the RAM read latency, and returns a one-cycle ready pulse with captured read data to the winning requester. It sits between the CPU control unit and the RAM wrapper.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
RD_LAT, 1, cycles from the RAM address-sampling edge until q is valid; legal values are 1..4

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous, active-high reset
fetchReq  in  1  fetch read request; held until fetchReady
fetchAddr  in  ADDR_W  fetch address
fetchReady  out  1  one-cycle pulse; rdata is valid for fetch
dataReq  in  1  data-port request; held until dataReady
dataWe  in  1  1 = write, 0 = read
dataAddr  in  ADDR_W  data-port address
dataWdata  in  DATA_W  write data
dataReady  out  1  one-cycle pulse; write is done, or rdata is valid
rdata  out  DATA_W  captured read data, shared by both ports
ramAddress  out  ADDR_W  to RAM address
ramData  out  DATA_W  to RAM data
ramWren  out  1  to RAM wren
ramRead  out  1  to RAM readMem
ramQ  in  DATA_W  from RAM out
busy  out  1  high whenever state != IDLE

Behaviour:
- All outputs are registered or decoded from registered state.
- Reset values: state=IDLE; ramAddress=0; ramData=0; ramWren=0; ramRead=0; rdata=0; fetchReady=0; dataReady=0; lastGrant=DATA (fetch wins the first tie); waitCnt=0.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port not equal to lastGrant (round-robin). Update lastGrant to the winner.
  - On grant, latch grantId, op (fetch is always a read), ramAddress, and ramData (data writes only). Go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Write: ramWren=1 for this cycle only. Next state is DONE.
  - Read: ramRead=1, ramWren=0. RAM samples the address at the end of this cycle. Load waitCnt=RD_LAT-1. Next state is WAIT.
- WAIT (RD_LAT cycles):
  - Decrement waitCnt each cycle.
  - When waitCnt==0, capture ramQ into rdata at the end of the cycle. Next state is DONE.
  - ramRead stays high throughout WAIT.
- DONE (1 cycle):
  - Assert fetchReady or dataReady per grantId. Exactly one is high; never both.
  - rdata holds until the next read capture.
  - Next state is IDLE.
- Latency from request seen in IDLE (cycle 0):
  - Write: ready in cycle 2.
  - Read: ready in cycle 2+RD_LAT (cycle 3 at the default).
  - Next grant is possible in cycle 3+RD_LAT for reads, cycle 3 for writes.
- Requests must drop in the cycle after ready. The DONE→IDLE gap guarantees a stale request is not re-granted.
- A request that drops before grant produces no access.
- A request that drops after grant still completes, and its ready still pulses.
- Address and data changes after grant are ignored (they were latched at grant).
- Reset asserted mid-transaction:
  - Next edge returns to IDLE with ramWren=0 and ramRead=0.
  - No ready pulse is issued for the aborted transaction.
  - A write whose ACCESS cycle coincides with reset is not guaranteed to land.
- ramData changes only on a data-write grant. ramAddress holds its last value while in IDLE.

Decomposition:
- Shared package/include holds: state encoding (IDLE=0, ACCESS=1, WAIT=2, DONE=3), requester IDs (REQ_FETCH=0, REQ_DATA=1), and the default RD_LAT.
- One natural sub-module: rr_pick2. It is a 2-way round-robin picker with inputs req[1:0] and lastGrant, and outputs valid and winner. It is purely combinational; lastGrant is held in ram_arbiter.

Test Plan:
- Reset, then dataReq write addr 0x0010 data 0xBEEF: ramWren high exactly 1 cycle; dataReady in cycle 2. Then a data read of 0x0010 returns rdata=0xBEEF with dataReady in cycle 3 (RD_LAT=1).
- Both ports request continuously, fetch 0x0100 and data read 0x0200, over 4 transactions: grant order is fetch, data, fetch, data. Ready pulses never overlap, and each rdata matches preloaded memory.
- RD_LAT=3 build, fetch read 0x0005 preloaded 0x1234: ramRead high for 4 cycles; fetchReady in cycle 5 with rdata=0x1234.
- Reset asserted during WAIT of a data read: state is IDLE next cycle; dataReady is never asserted; busy=0. A subsequent fetch completes normally.
- fetchReq pulsed for 1 cycle while a data write is in progress: no fetch access and no fetchReady. A data request dropped right after grant still yields one dataReady pulse.
